// File: rtl/fifo_stream_reader.sv
// Read-side consumer for the async FIFO: pulls words with credit-based `rd`,
// buffers them locally and re-presents them as a burst-framed valid/ready stream.
module fifo_stream_reader #(
  parameter int WIDTH     = 18,
  parameter int BUF_DEPTH = 4,
  parameter int BURST_LEN = 8
) (
  input  logic             rdclk,
  input  logic             reset,
  input  logic             enable,
  input  logic             empty,
  output logic             rd,
  input  logic [WIDTH-1:0] dataout,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             busy,
  output logic [31:0]      word_count
);

  localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [AW+1:0] DEPTH_W   = (AW+2)'(BUF_DEPTH);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [WIDTH-1:0] mem [BUF_DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      occ;
  logic             inflight;
  logic [BW-1:0]    beat;
  logic [AW+1:0]    credit_used;
  logic             push;
  logic             pop;

  // The word already requested but not yet captured holds a buffer slot, so
  // a read is only issued when a free entry is guaranteed at capture time.
  assign credit_used = {1'b0, occ} + {{(AW+1){1'b0}}, inflight};
  assign rd          = (state == RUN) && enable && !empty && (credit_used < DEPTH_W);

  // Stream handshake: a word transfers on a rising edge where m_valid && m_ready;
  // while m_valid && !m_ready the head entry and m_valid stay unchanged.
  assign push    = inflight;
  assign pop     = m_valid && m_ready;
  assign m_valid = (occ != '0);
  assign m_data  = mem[rptr];
  assign m_last  = m_valid && (beat == LAST_BEAT);
  assign busy    = (state != IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (enable) state_nx = RUN;
      RUN:     if (!enable) state_nx = DRAIN;
      DRAIN: begin
        if (enable)                       state_nx = RUN;
        else if (!inflight && occ == '0)  state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge rdclk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge rdclk or posedge reset) begin
    if (reset) begin
      inflight <= 1'b0;
    end else begin
      inflight <= rd;
    end
  end

  // Pointers wrap naturally because BUF_DEPTH is a power of two.
  always_ff @(posedge rdclk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wptr] <= dataout;
      wptr      <= wptr + AW'(1);
    end
  end

  always_ff @(posedge rdclk or posedge reset) begin
    if (reset) begin
      rptr <= '0;
    end else if (pop) begin
      rptr <= rptr + AW'(1);
    end
  end

  always_ff @(posedge rdclk or posedge reset) begin
    if (reset) begin
      occ <= '0;
    end else begin
      case ({push, pop})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Beat position survives enable toggles so framing stays aligned across pauses.
  always_ff @(posedge rdclk or posedge reset) begin
    if (reset) begin
      beat <= '0;
    end else if (pop) begin
      beat <= (beat == LAST_BEAT) ? '0 : beat + BW'(1);
    end
  end

  always_ff @(posedge rdclk or posedge reset) begin
    if (reset) begin
      word_count <= 32'd0;
    end else if (pop) begin
      word_count <= word_count + 32'd1;
    end
  end

  a_no_rd_when_empty: assert property (@(posedge rdclk) disable iff (reset) !(rd && empty));
  a_occ_bound:        assert property (@(posedge rdclk) disable iff (reset) occ <= (AW+1)'(BUF_DEPTH));

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a queue-based FIFO/stream model
// checked every cycle, plus literal expectations for each scenario.
module tb_fifo_stream_reader;

  localparam int W = 18;

  logic         rdclk;
  logic         reset;
  logic         enable;
  logic         empty;
  logic         rd;
  logic [W-1:0] dataout;
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ready;
  logic         m_last;
  logic         busy;
  logic [31:0]  word_count;

  fifo_stream_reader #(.WIDTH(W), .BUF_DEPTH(4), .BURST_LEN(8)) dut (
    .rdclk(rdclk), .reset(reset), .enable(enable), .empty(empty), .rd(rd),
    .dataout(dataout), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .busy(busy), .word_count(word_count)
  );

  // clock / reset
  initial rdclk = 1'b0;
  always #5 rdclk = ~rdclk;

  // FIFO source model: words are the pop index; `avail` words exist so far.
  int           avail = 0;
  int           popped = 0;
  logic         force_empty = 1'b0;
  assign empty = force_empty || (popped >= avail);

  // stream model / scoreboard
  logic [W-1:0] exp_q[$];
  int           cap = 0;
  int           del = 0;
  bit           infl = 1'b0;
  bit           pend = 1'b0;
  bit           prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;
  int           cyc = 0;
  int           rd_count = 0;
  int           rd_run = 0;
  int           rd_run_last = 0;
  int           last_cnt = 0;
  logic [W-1:0] last_word = '0;
  int           n_checks = 0;
  int           n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: sample/compare at negedge, then commit FIFO model at posedge+2.
  task automatic step();
    logic [W-1:0] e;
    @(negedge rdclk);
    cyc++;
    chk("rd_while_empty", {31'd0, rd && empty}, 32'd0);
    chk("m_valid_model", {31'd0, m_valid}, {31'd0, (cap != del)});
    if (prev_stall) begin
      chk("hold_valid", {31'd0, m_valid}, 32'd1);
      chk("hold_data", 32'(m_data), 32'(prev_data));
    end
    if (rd) begin
      rd_count++;
      rd_run++;
    end else if (rd_run > 0) begin
      rd_run_last = rd_run;
      rd_run = 0;
    end
    pend = rd && !empty;
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", 32'(m_data), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("stream_data", 32'(m_data), 32'(e));
      end
      chk("stream_last", {31'd0, m_last}, {31'd0, (del % 8) == 7});
      chk("stream_count", word_count, 32'(del));
      if (m_last) begin
        last_cnt++;
        last_word = m_data;
      end
      del++;
    end
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    @(posedge rdclk);
    #2;
    if (infl) begin
      cap++;
      infl = 1'b0;
    end
    if (pend) begin
      dataout = W'(popped);
      exp_q.push_back(W'(popped));
      popped++;
      infl = 1'b1;
      pend = 1'b0;
    end
  endtask

  task automatic run_until_del(input int target, input int budget);
    for (int i = 0; i < budget && del < target; i++) step();
  endtask

  int first_cyc;
  int last_cyc;
  int rc0;
  int base;

  initial begin
    reset = 1'b1; enable = 1'b0; m_ready = 1'b0; dataout = '0;
    #1;
    chk("rst_rd", {31'd0, rd}, 32'd0);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_last", {31'd0, m_last}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_word_count", word_count, 32'd0);
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // 20 preloaded words, always ready
    avail = 20; enable = 1'b1; m_ready = 1'b1;
    first_cyc = -1;
    for (int i = 0; i < 80 && del < 20; i++) begin
      step();
      if (del >= 1 && first_cyc < 0) first_cyc = cyc;
    end
    last_cyc = cyc;
    repeat (3) step();
    chk("t1_rd_run", 32'(rd_run_last), 32'd20);
    chk("t1_no_gaps", 32'(last_cyc - first_cyc), 32'd19);
    chk("t1_word_count", word_count, 32'd20);
    chk("t1_rd_low", {31'd0, rd}, 32'd0);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_last_cnt", 32'(last_cnt), 32'd2);
    chk("t1_last_word", 32'(last_word), 32'h0000F);

    // backpressure: 10 words, ready low
    m_ready = 1'b0; avail = 30; rc0 = rd_count;
    repeat (10) step();
    chk("t2_reads", 32'(rd_count - rc0), 32'd4);
    chk("t2_rd_low", {31'd0, rd}, 32'd0);
    chk("t2_valid", {31'd0, m_valid}, 32'd1);
    chk("t2_head", 32'(m_data), 32'h00014);
    m_ready = 1'b1;
    run_until_del(30, 60);
    repeat (2) step();
    chk("t2_word_count", word_count, 32'd30);
    chk("t2_rd_low_end", {31'd0, rd}, 32'd0);

    // empty toggling every cycle
    avail = 38;
    for (int i = 0; i < 80 && del < 38; i++) begin
      force_empty = ~force_empty;
      step();
    end
    force_empty = 1'b0;
    repeat (2) step();
    chk("t3_word_count", word_count, 32'd38);
    chk("t3_last_cnt", 32'(last_cnt), 32'd4);

    // enable dropped with 3 buffered + 1 inflight
    m_ready = 1'b0; avail = 44;
    for (int i = 0; i < 20 && !((cap - del) == 3 && infl); i++) step();
    chk("t4_valid_before", {31'd0, m_valid}, 32'd1);
    enable = 1'b0; m_ready = 1'b1; rc0 = rd_count;
    repeat (12) step();
    chk("t4_no_reads", 32'(rd_count - rc0), 32'd0);
    chk("t4_word_count", word_count, 32'd42);
    chk("t4_busy_idle", {31'd0, busy}, 32'd0);
    chk("t4_valid_after", {31'd0, m_valid}, 32'd0);
    enable = 1'b1; avail = 48;
    run_until_del(48, 60);
    repeat (2) step();
    chk("t4_word_count_end", word_count, 32'd48);
    chk("t4_last_cnt", 32'(last_cnt), 32'd6);
    chk("t4_last_word", 32'(last_word), 32'h0002F);

    // async reset mid-burst with occupancy 3
    m_ready = 1'b0; avail = 53;
    for (int i = 0; i < 20 && (cap - del) != 3; i++) step();
    #1;
    chk("t5_valid_pre", {31'd0, m_valid}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("t5_rd_async", {31'd0, rd}, 32'd0);
    chk("t5_valid_async", {31'd0, m_valid}, 32'd0);
    chk("t5_last_async", {31'd0, m_last}, 32'd0);
    chk("t5_count_async", word_count, 32'd0);
    exp_q.delete();
    cap = 0; del = 0; infl = 1'b0; pend = 1'b0; prev_stall = 1'b0;
    #4;
    reset = 1'b0;
    chk("t5_count_release", word_count, 32'd0);
    base = popped;
    avail = popped + 8; m_ready = 1'b1;
    run_until_del(8, 60);
    repeat (2) step();
    chk("t5_word_count", word_count, 32'd8);
    chk("t5_last_cnt", 32'(last_cnt), 32'd7);
    chk("t5_last_word", 32'(last_word), 32'(base + 7));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side consumer for the async FIFO; sits entirely in the rdclk domain.
- Drives the FIFO `rd` strobe from `empty` and local buffer credit, and captures `dataout`.
- Re-presents the captured words as a valid/ready stream with burst framing (`m_last`).
- Guarantees no read while empty, no dropped words under downstream backpressure, and full throughput when downstream is always ready.

Parameters:
- WIDTH, 18: data word width; equals FIFO WIDTH.
- BUF_DEPTH, 4: output buffer entries; must be >= 2, power of two.
- BURST_LEN, 8: words per burst; `m_last` marks the final word of each burst; must be >= 1.

Ports:
- rdclk, input, 1: sole clock; all logic on posedge.
- reset, input, 1: asynchronous, active-high; clears all state.
- enable, input, 1: level; permits new FIFO reads.
- empty, input, 1: FIFO empty flag, rdclk domain.
- rd, output, 1: FIFO read strobe.
- dataout, input, WIDTH: FIFO read data, valid exactly 1 cycle after an accepted `rd`.
- m_data, output, WIDTH: stream data (head of buffer).
- m_valid, output, 1: stream valid.
- m_ready, input, 1: stream ready.
- m_last, output, 1: head word is the last of a burst.
- busy, output, 1: state != IDLE.
- word_count, output, 32: total words delivered (`m_valid` && `m_ready`) since reset; wraps.

Behaviour:
- Reset (async assert, sync deassert assumed upstream):
  - `rd`, `m_valid`, `m_last`, `busy` = 0; `m_data` = 0; `word_count` = 0.
  - Buffer occupancy = 0; inflight flag = 0; beat counter = 0; state = IDLE.
  - Reset mid-operation discards any buffered or inflight words. Words already popped from the FIFO are lost; this is accepted.
- FIFO read timing:
  - A read is accepted at a posedge where `rd` = 1 and `empty` = 0.
  - `dataout` is captured into the buffer at the next posedge. Inflight flag is set for exactly that cycle.
- rd generation:
  - Combinational from registered state: `rd` = (state == RUN) && !`empty` && (occupancy + inflight < BUF_DEPTH).
  - `rd` is never asserted while `empty` = 1.
  - With `m_ready` held high, `rd` may stay high every cycle: 1 word/cycle sustained.
- Buffer:
  - Circular FIFO of BUF_DEPTH entries with wrapping read and write pointers.
  - Capture and pop in the same cycle leave occupancy unchanged.
  - Occupancy never exceeds BUF_DEPTH. Credit accounting covers the inflight word, so no overflow is possible.
- Stream:
  - `m_valid` = occupancy != 0; `m_data` = head entry.
  - Transfer happens on a posedge with `m_valid` && `m_ready`.
  - `m_data` and `m_valid` hold stable while `m_valid` && !`m_ready`.
  - Latency: `rd` accepted at edge N → `m_valid` high after edge N+1, with an empty buffer.
- Framing:
  - Beat counter increments per transfer and wraps BURST_LEN-1 → 0.
  - `m_last` = `m_valid` && (beat == BURST_LEN-1).
  - Beat counter persists across enable toggles and clears only on reset.
- State machine:
  - IDLE: `enable` = 1 → RUN.
  - RUN: issue reads per the rule above. `enable` = 0 → DRAIN (no new `rd` from that cycle).
  - DRAIN: no reads. When inflight = 0 and occupancy = 0 → IDLE. If `enable` returns to 1 while in DRAIN → RUN directly.
- `word_count`: +1 per transfer, modulo 2^32.

Test Plan:
- Reset, then `enable` = 1, `m_ready` = 1; FIFO preloaded with 0x00000..0x00013 (20 words):
  - `rd` high for 20 consecutive cycles.
  - `m_data` sequence 0x00000..0x00013 in order, with no gaps after the first.
  - `m_last` on words 7 and 15.
  - `word_count` = 20; `empty` → `rd` low; `busy` remains 1 (RUN).
- `m_ready` = 0, FIFO holding 10 words:
  - Exactly 4 reads occur, then `rd` stays 0.
  - `m_data` holds the first word stable.
  - Raising `m_ready` delivers all 10 words in order, with no duplicates or drops.
- `empty` toggling every cycle with `m_ready` = 1:
  - `rd` never asserted while `empty` = 1.
  - Output order is preserved.
- `enable` dropped while 3 words are buffered and 1 is inflight:
  - No further `rd`.
  - All 4 words are delivered, then `busy` → 0 (IDLE).
  - Re-enable resumes the beat count; `m_last` stays aligned.
- Async `reset` pulsed mid-burst (between edges) with buffer occupancy 3:
  - `rd`, `m_valid`, `m_last` drop immediately, without waiting for a clock edge.
  - `word_count` = 0 and beat counter = 0 after release.
  - The next delivered word carries `m_last` only at the 8th beat.
